backprop_chain_engine: RTL

Sequential successor to the combinational per-layer backprop stack. It stores per-layer gradient vectors (dy/dw) and Jacobian matrices (dy/dy_old) for up to MAX_LAYERS layers, loaded one row per beat over a valid/ready stream. On request it computes dc_dw[r] = sum_c grad[L][c] * jac[L+1][r][c] with one multiply-accumulate per cycle, and emits the result vector over a valid/ready output. Arithmetic is signed fixed point with saturation. The block sits between the forward datapath's derivative taps and the weight-update unit.

---
 rtl/backprop_pkg.sv | 46 ++++
 rtl/backprop_mac_unit.sv | 48 ++++
 rtl/backprop_chain_engine.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/backprop_pkg.sv
// rtl/backprop_pkg.sv - shared types, default widths and fixed-point helpers for the backprop chain engine.
// BACKPROP_ROUND_EN selects round-half-up instead of floor in the fixed-point shift.
package backprop_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MAC,
        ST_EMIT
    } state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_FRAC_W = 4;

    typedef struct packed {
        logic signed [31:0] value;
        logic               ovf;
    } sat_t;

    function automatic sat_t sat(input logic signed [63:0] x, input int data_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t               s;
        hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (data_w - 1));
        if (x > hi) begin
            s.value = hi[31:0];
            s.ovf   = 1'b1;
        end else if (x < lo) begin
            s.value = lo[31:0];
            s.ovf   = 1'b1;
        end else begin
            s.value = x[31:0];
            s.ovf   = 1'b0;
        end
        return s;
    endfunction

    function automatic logic signed [63:0] fx_shift(input logic signed [63:0] x, input int frac_w);
`ifdef BACKPROP_ROUND_EN
        return (x + (64'sd1 <<< (frac_w - 1))) >>> frac_w;
`else
        return x >>> frac_w;
`endif
    endfunction

endpackage

// File: rtl/backprop_mac_unit.sv
// rtl/backprop_mac_unit.sv - signed multiply-accumulate with fixed-point shift and saturation.
// Rounding mode follows BACKPROP_ROUND_EN through the package shift helper.
module backprop_mac_unit
    import backprop_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int FRAC_W = DEF_FRAC_W,
    parameter int SIZE   = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     flush,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] res,
    output logic                     ovf
);
    localparam int ACC_W = 2 * DATA_W + $clog2(SIZE) + 1;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    sum;
    sat_t                       s;
    logic                       unused_hi;

    // The result is formed from the sum including the current product, so the
    // flush cycle both completes a row and restarts the accumulator at zero.
    always_comb begin
        prod = a * b;
        sum  = acc + ACC_W'(prod);
        s    = sat(fx_shift(64'(sum), FRAC_W), DATA_W);
        res  = s.value[DATA_W-1:0];
        ovf  = s.ovf;
    end

    assign unused_hi = ^s.value[31:DATA_W];

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= flush ? '0 : sum;
        end
    end

endmodule

// File: rtl/backprop_chain_engine.sv
// rtl/backprop_chain_engine.sv - stores per-layer gradients/Jacobians and computes dc_dw one MAC per cycle.
// Build option BACKPROP_ROUND_EN switches the result shift from floor to round-half-up.
module backprop_chain_engine
    import backprop_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int FRAC_W     = DEF_FRAC_W,
    parameter int SIZE       = 3,
    parameter int MAX_LAYERS = 4,
    parameter int LIDX_W     = $clog2(MAX_LAYERS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LIDX_W-1:0]      in_layer,
    input  logic [SIZE*DATA_W-1:0] in_jac_row,
    input  logic [DATA_W-1:0]      in_grad,
    input  logic                   start,
    input  logic [LIDX_W-1:0]      start_layer,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SIZE*DATA_W-1:0] out_data,
    output logic [LIDX_W-1:0]      out_layer,
    output logic                   sat_flag,
    output logic                   err_flag
);
    localparam int ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [ROW_W-1:0] LAST = ROW_W'(SIZE - 1);

    logic signed [DATA_W-1:0] jac  [MAX_LAYERS][SIZE][SIZE];
    logic signed [DATA_W-1:0] grad [MAX_LAYERS][SIZE];
    logic signed [DATA_W-1:0] res  [SIZE];

    state_t                   state;
    logic [MAX_LAYERS-1:0]    loaded;
    logic [ROW_W-1:0]         row;
    logic [ROW_W-1:0]         wr_row;
    logic [ROW_W-1:0]         r;
    logic [ROW_W-1:0]         c;
    logic [LIDX_W-1:0]        load_layer;
    logic [LIDX_W-1:0]        cur_layer;
    logic [LIDX_W-1:0]        jac_layer;
    logic [LIDX_W-1:0]        next_layer;
    logic                     accept;
    logic                     discard;
    logic                     legal;
    logic                     mac_clr;
    logic                     mac_en;
    logic                     flush;
    logic                     mac_ovf;
    logic signed [DATA_W-1:0] mac_a;
    logic signed [DATA_W-1:0] mac_b;
    logic signed [DATA_W-1:0] mac_res;

    assign in_ready   = (state == ST_IDLE) && !start;
    assign busy       = (state != ST_IDLE);
    assign accept     = in_valid && in_ready;
    // A layer switch mid-load abandons the old layer; the beat restarts at row 0.
    assign discard    = accept && (row != '0) && (in_layer != load_layer);
    assign wr_row     = discard ? '0 : row;
    assign next_layer = start_layer + LIDX_W'(1);
    assign legal      = ((int'(start_layer) + 1) < MAX_LAYERS)
                        && loaded[start_layer] && loaded[next_layer];
    assign mac_clr    = (state == ST_IDLE) && start && legal;
    assign mac_en     = (state == ST_MAC);
    assign flush      = mac_en && (c == LAST);
    assign jac_layer  = cur_layer + LIDX_W'(1);
    assign mac_a      = grad[cur_layer][c];
    assign mac_b      = jac[jac_layer][r][c];

    backprop_mac_unit #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .SIZE   (SIZE)
    ) u_mac (
        .clk   (clk),
        .reset (reset),
        .clr   (mac_clr),
        .en    (mac_en),
        .flush (flush),
        .a     (mac_a),
        .b     (mac_b),
        .res   (mac_res),
        .ovf   (mac_ovf)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            grad[in_layer][wr_row] <= in_grad;
            for (int i = 0; i < SIZE; i++) begin
                jac[in_layer][wr_row][i] <= in_jac_row[(SIZE-1-i)*DATA_W +: DATA_W];
            end
        end
        if (flush) begin
            res[r] <= mac_res;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            row        <= '0;
            load_layer <= '0;
            loaded     <= '0;
            r          <= '0;
            c          <= '0;
            cur_layer  <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_layer  <= '0;
            sat_flag   <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            if (accept) begin
                load_layer <= in_layer;
                row        <= (wr_row == LAST) ? '0 : wr_row + ROW_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (start && legal) begin
                        state     <= ST_MAC;
                        r         <= '0;
                        c         <= '0;
                        cur_layer <= start_layer;
                    end
                end
                ST_MAC: begin
                    if (flush) begin
                        c <= '0;
                        r <= r + ROW_W'(1);
                        if (r == LAST) begin
                            state     <= ST_EMIT;
                            out_valid <= 1'b1;
                            out_layer <= cur_layer;
                            // The last element is still in flight from the MAC this cycle.
                            for (int i = 0; i < SIZE; i++) begin
                                out_data[(SIZE-1-i)*DATA_W +: DATA_W] <=
                                    (i == SIZE - 1) ? mac_res : res[i];
                            end
                        end
                    end else begin
                        c <= c + ROW_W'(1);
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (clear) begin
                loaded   <= '0;
                sat_flag <= 1'b0;
                err_flag <= 1'b0;
            end else begin
                if (discard) begin
                    loaded[load_layer] <= 1'b0;
                end
                if (accept && (wr_row == LAST)) begin
                    loaded[in_layer] <= 1'b1;
                end
                if (flush && mac_ovf) begin
                    sat_flag <= 1'b1;
                end
                if (discard || ((state == ST_IDLE) && start && !legal)) begin
                    err_flag <= 1'b1;
                end
            end
        end
    end

endmodule
